// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: this interface bundles the PC, instruction-memory, execute-stage and status signals of pc_sequencer.
// master = the sequencer side, slave = the PC, memory and execute side that sits around it.
interface pc_sequencer_if #(
  parameter int AW = 8,
  parameter int IW = 16
);
  logic [AW-1:0] pcValue;
  logic          pcHold;
  logic          pcJump;
  logic [AW-1:0] pcJumpLine;
  logic          imemReq;
  logic          imemReady;
  logic [IW-1:0] instr;
  logic [IW-1:0] irOut;
  logic          exStart;
  logic          exBusy;
  logic          exBranch;
  logic          exTaken;
  logic [AW-1:0] exTarget;
  logic          isHalt;
  logic          resume;
  logic          fault;
  logic [15:0]   retired;
  logic [1:0]    state;
  logic          irq;
  logic          isRti;
  logic          irqAck;
  modport master (
    input  pcValue, imemReady, instr, exBusy, exBranch, exTaken, exTarget, isHalt, resume, irq, isRti,
    output pcHold, pcJump, pcJumpLine, imemReq, irOut, exStart, fault, retired, state, irqAck
  );
  modport slave (
    output pcValue, imemReady, instr, exBusy, exBranch, exTaken, exTarget, isHalt, resume, irq, isRti,
    input  pcHold, pcJump, pcJumpLine, imemReq, irOut, exStart, fault, retired, state, irqAck
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute controller that drives the PC hold/jump inputs, issues fetches and latches the IR.
// Ports: clk, reset (synchronous, active-high); bus (pc_sequencer_if.master) carries the PC, imem, execute and status signals.
// Optional SEQ_IRQ_EN adds interrupt entry (irq/irqAck) and return-from-interrupt (isRti) through an epc register.
module pc_sequencer #(
  parameter int AW = 8,
  parameter int IW = 16,
  parameter int FETCH_TIMEOUT = 15,
  parameter logic [AW-1:0] IRQ_VECTOR = 8'hF0
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);
  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2, FAULT = 2'd3} state_t;
  state_t        r_state;
  logic [7:0]    r_timer;
  logic          r_first;
  logic [IW-1:0] r_ir;
  logic [15:0]   r_retired;
  logic          w_done, w_taken, w_irq, w_rti, w_adv, w_jump;
  logic [AW-1:0] w_inc, w_line;
  assign w_done  = r_state == EXEC && !bus.exBusy;
  assign w_taken = bus.exBranch && bus.exTaken;
  assign w_inc   = bus.pcValue + 1'b1;
`ifdef SEQ_IRQ_EN
  logic [AW-1:0] r_epc;
  logic          r_ie;
  // RTI outranks both branch and irq; a pending irq in HALT behaves as resume into the vector
  assign w_rti  = w_done && !bus.isHalt && bus.isRti;
  assign w_irq  = r_ie && bus.irq && ((w_done && !bus.isHalt && !bus.isRti) || r_state == HALT);
  assign w_line = !w_jump ? '0 : w_irq ? IRQ_VECTOR : w_rti ? r_epc : bus.exTarget;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_epc <= '0;
      r_ie  <= 1'b1;
    end else if (w_irq) begin
      r_epc <= (r_state == HALT || !w_taken) ? w_inc : bus.exTarget;
      r_ie  <= 1'b0;
    end else if (w_rti) begin
      r_ie  <= 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_rti    = 1'b0;
  assign w_irq    = 1'b0;
  assign w_line   = w_jump ? bus.exTarget : '0;
  assign w_unused = ^{IRQ_VECTOR, bus.irq, bus.isRti, w_inc};
`endif
  // the single cycle per instruction in which the PC is released
  assign w_adv  = !reset && ((w_done && !bus.isHalt) || (r_state == HALT && (bus.resume || w_irq)));
  assign w_jump = w_adv && (w_irq || w_rti || (w_done && w_taken));
  assign bus.pcHold     = !w_adv;
  assign bus.pcJump     = w_jump;
  assign bus.pcJumpLine = w_line;
  assign bus.imemReq    = !reset && r_state == FETCH;
  assign bus.exStart    = !reset && r_state == EXEC && r_first;
  assign bus.irqAck     = !reset && w_irq;
  assign bus.irOut      = r_ir;
  assign bus.fault      = r_state == FAULT;
  assign bus.retired    = r_retired;
  assign bus.state      = r_state;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_timer   <= '0;
      r_first   <= 1'b0;
      r_ir      <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (bus.imemReady) begin
            r_ir    <= bus.instr;
            r_timer <= '0;
            r_first <= 1'b1;
            r_state <= EXEC;
          end else if (r_timer == 8'(FETCH_TIMEOUT - 1)) begin
            r_state <= FAULT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        EXEC: begin
          r_first <= 1'b0;
          if (!bus.exBusy) begin
            r_retired <= r_retired + 1'b1;
            r_state   <= bus.isHalt ? HALT : FETCH;
          end
        end
        HALT: if (bus.resume || w_irq) r_state <= FETCH;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench with a behavioural PC and instruction memory around pc_sequencer.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pc_sequencer_if #(.AW(8), .IW(16)) bus ();
  pc_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  logic [7:0] pc;
  logic       rdy = 1'b1, br_en = 1'b0, busy_en = 1'b0, halt_en = 1'b0, irq_en = 1'b0, rti_en = 1'b0, res = 1'b0;
  int         busy_cnt = 0;
  int         tests = 0, fails = 0, n_start = 0, n_ack = 0;
  logic [7:0] exp_fetch[$];
  logic [7:0] exp_jump[$];
  logic [7:0] last_addr = '0;
  always @(posedge clk) begin
    if (reset) pc <= 8'h00;
    else if (!bus.pcHold) pc <= bus.pcJump ? bus.pcJumpLine : pc + 8'h01;
    busy_cnt <= (bus.state == 2'd1) ? busy_cnt + 1 : 0;
  end
  assign bus.pcValue   = pc;
  assign bus.imemReady = rdy;
  assign bus.instr     = {8'hA5, pc};
  assign bus.exBusy    = busy_en && pc == 8'h02 && bus.state == 2'd1 && busy_cnt < 3;
  assign bus.exBranch  = br_en && pc == 8'h05;
  assign bus.exTaken   = 1'b1;
  assign bus.exTarget  = 8'h20;
  assign bus.isHalt    = halt_en && pc == 8'h09;
  assign bus.resume    = res;
  assign bus.irq       = irq_en && pc == 8'h03;
  assign bus.isRti     = rti_en && pc == 8'hF2;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.imemReq && bus.imemReady) begin
        if (exp_fetch.size() == 0) chk("unexpected_fetch", {24'h0, pc}, 32'hFFFF_FFFF);
        else begin
          last_addr = exp_fetch.pop_front();
          chk("fetch_addr", {24'h0, pc}, {24'h0, last_addr});
        end
      end
      if (bus.exStart) begin
        n_start++;
        chk("ir_out", {16'h0, bus.irOut}, {16'h0, 8'hA5, last_addr});
      end
      if (!bus.pcHold) begin
        if (!bus.pcJump) chk("line_zero", {24'h0, bus.pcJumpLine}, 32'h0);
        else if (exp_jump.size() == 0) chk("unexpected_jump", {24'h0, bus.pcJumpLine}, 32'hFFFF_FFFF);
        else chk("jump_line", {24'h0, bus.pcJumpLine}, {24'h0, exp_jump.pop_front()});
      end
      if (bus.exBusy) chk("hold_busy", {31'h0, bus.pcHold}, 32'h1);
      if (bus.irqAck) n_ack++;
    end
  end
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {30'h0, bus.state}, 32'h0);
    chk("rst_fault", {31'h0, bus.fault}, 32'h0);
    chk("rst_retired", {16'h0, bus.retired}, 32'h0);
    chk("rst_ir", {16'h0, bus.irOut}, 32'h0);
    chk("rst_hold", {31'h0, bus.pcHold}, 32'h1);
    chk("rst_req", {30'h0, bus.imemReq, bus.exStart}, 32'h0);
    chk("drained", exp_fetch.size() + exp_jump.size(), 32'h0);
    exp_fetch.delete();
    exp_jump.delete();
    {rdy, br_en, busy_en, halt_en, irq_en, rti_en, res} = 7'b1000000;
    n_start = 0;
    n_ack = 0;
  endtask
  task automatic run(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 6; i++) exp_fetch.push_back(8'(i));
    reset = 1'b0;
    run(12);
    chk("seq_retired", {16'h0, bus.retired}, 32'd6);
    chk("seq_starts", n_start, 32'd6);
    do_reset();
    br_en = 1'b1;
    for (int i = 0; i < 6; i++) exp_fetch.push_back(8'(i));
    exp_fetch.push_back(8'h20);
    exp_fetch.push_back(8'h21);
    exp_jump.push_back(8'h20);
    reset = 1'b0;
    run(16);
    chk("br_retired", {16'h0, bus.retired}, 32'd8);
    chk("br_pc", {24'h0, pc}, 32'h22);
    do_reset();
    busy_en = 1'b1;
    for (int i = 0; i < 4; i++) exp_fetch.push_back(8'(i));
    reset = 1'b0;
    run(11);
    chk("busy_retired", {16'h0, bus.retired}, 32'd4);
    chk("busy_starts", n_start, 32'd4);
    chk("busy_pc", {24'h0, pc}, 32'h4);
    do_reset();
    rdy = 1'b0;
    reset = 1'b0;
    run(15);
    chk("to_state", {30'h0, bus.state}, 32'd3);
    chk("to_fault", {31'h0, bus.fault}, 32'h1);
    rdy = 1'b1;
    run(5);
    chk("to_sticky_state", {30'h0, bus.state}, 32'd3);
    chk("to_sticky_fault", {31'h0, bus.fault}, 32'h1);
    do_reset();
    rdy = 1'b0;
    reset = 1'b0;
    run(14);
    exp_fetch.push_back(8'h00);
    rdy = 1'b1;
    run(1);
    chk("late_state", {30'h0, bus.state}, 32'd1);
    chk("late_fault", {31'h0, bus.fault}, 32'h0);
    do_reset();
    halt_en = 1'b1;
    res = 1'b1;
    for (int i = 0; i < 11; i++) exp_fetch.push_back(8'(i));
    reset = 1'b0;
    run(10);
    res = 1'b0;
    run(10);
    chk("halt_state", {30'h0, bus.state}, 32'd2);
    chk("halt_retired", {16'h0, bus.retired}, 32'd10);
    run(5);
    chk("halt_pc", {24'h0, pc}, 32'h9);
    chk("halt_stay", {30'h0, bus.state}, 32'd2);
    res = 1'b1;
    run(1);
    res = 1'b0;
    chk("resume_pc", {24'h0, pc}, 32'hA);
    chk("resume_state", {30'h0, bus.state}, 32'd0);
    run(2);
    chk("resume_retired", {16'h0, bus.retired}, 32'd11);
    do_reset();
    irq_en = 1'b1;
    rti_en = 1'b1;
`ifdef SEQ_IRQ_EN
    for (int i = 0; i < 4; i++) exp_fetch.push_back(8'(i));
    exp_fetch.push_back(8'hF0);
    exp_fetch.push_back(8'hF1);
    exp_fetch.push_back(8'hF2);
    exp_fetch.push_back(8'h04);
    exp_jump.push_back(8'hF0);
    exp_jump.push_back(8'h04);
    reset = 1'b0;
    run(16);
    chk("irq_acks", n_ack, 32'd1);
    chk("irq_pc", {24'h0, pc}, 32'h5);
`else
    for (int i = 0; i < 8; i++) exp_fetch.push_back(8'(i));
    reset = 1'b0;
    run(16);
    chk("irq_acks", n_ack, 32'd0);
    chk("irq_pc", {24'h0, pc}, 32'h8);
`endif
    chk("irq_retired", {16'h0, bus.retired}, 32'd8);
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
